svnet_ram_stream_reader: RTL and testbench
==========================================

Name: svnet_ram_stream_reader

Overview:
- Read-side sequencer for svnet_ram.
- On a start command it issues a burst of `start_length` reads at consecutive addresses, respecting the RAM read-to-read spacing.
- It captures `read_data_valid`/`read_data` into an internal response FIFO and presents the data as a valid/ready stream to the next compute stage.
- Credit-based issue guarantees the response FIFO can never overflow under downstream backpressure.

Parameters:
- DEPTH, 1024, RAM word count; address width is `$clog2(DEPTH)`.
- WIDTH, 8, RAM word width in bits.
- READ_LATENCY, 2, cycles from `ram_read` asserted to `ram_read_data_valid`.
- READ_GAP, 2, minimum cycles between successive `ram_read` pulses (≥1).
- FIFO_DEPTH, 4, response FIFO entries; power of 2, ≥ READ_LATENCY.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin burst; sampled only in IDLE.
- start_base  input  $clog2(DEPTH)  first read address.
- start_length  input  $clog2(DEPTH)+1  word count, 0..DEPTH.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at burst completion.
- ram_read  output  1  read strobe to RAM.
- ram_read_address  output  $clog2(DEPTH)  read address to RAM.
- ram_read_data_valid  input  1  RAM response valid.
- ram_read_data  input  WIDTH  RAM response data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  WIDTH  stream data.
- out_last  output  1  high on the final word of a burst.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; busy, done, ram_read, out_valid, out_last = 0; ram_read_address, out_data = 0; all counters and FIFO pointers = 0.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN.
  - IDLE: on start with start_length > 0, latch base/length, busy = 1, go to ISSUE.
  - IDLE: on start with start_length = 0, pulse done the next cycle, issue no reads, busy stays 0.
- ISSUE: assert ram_read for one cycle when both hold:
  - gap counter has expired, i.e. ≥ READ_GAP cycles since the previous ram_read;
  - credits are available: outstanding + fifo_count < FIFO_DEPTH.
- Each issued read increments outstanding; each ram_read_data_valid decrements outstanding and pushes ram_read_data into the FIFO in the same cycle.
- Address sequence is base, base+1, …, wrapping from DEPTH-1 to 0. DEPTH need not be a power of 2, so the wrap is an explicit compare, not a bit truncation.
- After the last read is issued, go to DRAIN.
- DRAIN: wait for outstanding = 0 and the FIFO to be empty with the last word accepted. Then pulse done, clear busy, return to IDLE.
  - done and the IDLE transition occur the cycle after the last out_valid && out_ready handshake.
- Stream: out_valid = FIFO not empty; out_data/out_last come from the FIFO head.
  - out_last is stored with each entry and tagged on the final issued read.
- Data must be held stable while out_valid && !out_ready.
- Simultaneous FIFO push and pop is allowed at any occupancy, including full; count stays unchanged.
- Credit rule: the FIFO never overflows; the bench asserts push when full is never observed.
- start while busy is ignored, with no effect on the current burst.
- ram_read_data_valid with outstanding = 0 is an error: assertion fires and the data is dropped.
- Reset mid-burst: everything returns to the reset state immediately. Late RAM responses arriving after reset deassertion are not expected; the upstream resets together.
- Throughput with out_ready = 1 and READ_GAP = 2: one word every 2 cycles. First out_valid appears READ_LATENCY+1 cycles after the first ram_read.

Optional Feature:
- Macro: SVNET_RAM_STREAM_READER_STATS_EN.
- With the macro defined:
  - adds output `stall_cycles`, 32 bits, registered;
  - counts cycles with out_valid && !out_ready;
  - saturates at 2^32-1;
  - clears to 0 on reset and on every accepted start.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then start base=5, length=4, out_ready=1, RAM model contents addr k = k: ram_read at addresses 5,6,7,8 spaced exactly 2 cycles; out_data 5,6,7,8; out_last only on 8; one done pulse; busy low afterwards.
- DEPTH=10, start base=8, length=4: addresses 8,9,0,1; out_data follows in the same order.
- Backpressure: length=16, out_ready=0 for 20 cycles:
  - exactly FIFO_DEPTH=4 reads issued, then ram_read stays 0;
  - out_data held stable;
  - after out_ready=1, all 16 words arrive in order and the FIFO never overflows.
- start with length=0: done pulses the next cycle, no ram_read, busy stays 0. A second start while a length=8 burst is busy is ignored; exactly 8 words are emitted.
- Assert rst mid-burst after 3 of 8 words: all outputs return to reset values asynchronously. A fresh start base=0, length=2 then completes correctly.
- With STATS_EN: length=4, out_ready held low for 7 cycles while out_valid=1 → stall_cycles=7. The next start clears it to 0.

Source files
------------

// File: rtl/svnet_ram_stream_reader.sv
// Burst read sequencer for svnet_ram: paced, credit-limited reads feeding a valid/ready stream.
// Optional stall counter output enabled by SVNET_RAM_STREAM_READER_STATS_EN.
module svnet_ram_stream_reader #(
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 2,
  parameter int READ_GAP     = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    start_base,
  input  logic [AW:0]      start_length,
  output logic             busy,
  output logic             done,
  output logic             ram_read,
  output logic [AW-1:0]    ram_read_address,
  input  logic             ram_read_data_valid,
  input  logic [WIDTH-1:0] ram_read_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
  , output logic [31:0]    stall_cycles
`endif
);

  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(READ_GAP + 1);

  if (FIFO_DEPTH < READ_LATENCY) begin : g_cfg_chk
    $error("FIFO_DEPTH must be >= READ_LATENCY");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                          state_q, state_d;
  logic [AW-1:0]                   nxt_addr_q, nxt_addr_d;
  logic [AW:0]                     rem_q, rem_d;
  logic [GW-1:0]                   gap_q, gap_d;
  logic [CW-1:0]                   outst_q, outst_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [FW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH-1:0][WIDTH:0]  mem_q, mem_d;
  logic                            busy_q, busy_d, done_q, done_d, rd_q, rd_d;
  logic [AW-1:0]                   addr_q, addr_d;
  logic                            vld_q, vld_d, last_q, last_d;
  logic [WIDTH-1:0]                data_q, data_d;
  logic                            issue, push, pop, tag;
  logic [CW:0]                     credit_sum;
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
  logic [31:0]                     stall_q, stall_d;
`endif

  assign pop        = vld_q & out_ready;
  assign push       = ram_read_data_valid & (outst_q != '0);
  // Responses return in order, so the one retiring the final outstanding read in DRAIN is the last word.
  assign tag        = (state_q == DRAIN) && (outst_q == CW'(1));
  assign credit_sum = {1'b0, outst_q} + {1'b0, cnt_q};

  always_comb begin
    state_d    = state_q;
    nxt_addr_d = nxt_addr_q;
    rem_d      = rem_q;
    gap_d      = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_d       = 1'b0;
    addr_d     = addr_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_length != '0) begin
            nxt_addr_d = start_base;
            rem_d      = start_length;
            busy_d     = 1'b1;
            state_d    = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Credits count both in-flight reads and buffered words, so a full FIFO blocks issue.
        if (gap_q == '0 && credit_sum < (CW+1)'(FIFO_DEPTH)) begin
          issue      = 1'b1;
          rd_d       = 1'b1;
          addr_d     = nxt_addr_q;
          nxt_addr_d = (nxt_addr_q == AW'(DEPTH - 1)) ? '0 : nxt_addr_q + AW'(1);
          rem_d      = rem_q - (AW+1)'(1);
          gap_d      = GW'(READ_GAP - 1);
          if (rem_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    outst_d  = outst_q + CW'(issue) - CW'(push);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {tag, ram_read_data};
      wr_ptr_d        = wr_ptr_q + FW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Head is taken from the post-push array so a word landing in an empty FIFO shows next cycle.
    vld_d  = (cnt_d != '0);
    data_d = data_q;
    last_d = last_q;
    if (cnt_d != '0) {last_d, data_d} = mem_d[rd_ptr_d];
    else             last_d = 1'b0;

`ifdef SVNET_RAM_STREAM_READER_STATS_EN
    stall_d = stall_q;
    if (state_q == IDLE && start)                    stall_d = '0;
    else if (vld_q && !out_ready && stall_q != '1)   stall_d = stall_q + 32'd1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      nxt_addr_q <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      outst_q    <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      nxt_addr_q <= nxt_addr_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      outst_q    <= outst_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      last_q     <= last_d;
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // A response with nothing outstanding is an upstream protocol error; its data is dropped.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    ram_read_data_valid |-> (outst_q != '0));

  assign busy             = busy_q;
  assign done             = done_q;
  assign ram_read         = rd_q;
  assign ram_read_address = addr_q;
  assign out_valid        = vld_q;
  assign out_data         = data_q;
  assign out_last         = last_q;
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
  assign stall_cycles     = stall_q;
`endif

endmodule

// File: tb/tb_svnet_ram_stream_reader.sv
// Bench for svnet_ram_stream_reader: RAM model, queue-based reference model, directed + random bursts.
module tb_svnet_ram_stream_reader;
  localparam int DEPTH = 20, WIDTH = 8, RL = 2, RG = 2, FD = 4;
  localparam int AW = $clog2(DEPTH);

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0]    start_base = '0;
  logic [AW:0]      start_length = '0;
  logic             busy, done, ram_read, ram_read_data_valid, out_valid, out_last;
  logic [AW-1:0]    ram_read_address;
  logic [WIDTH-1:0] ram_read_data, out_data;
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
  logic [31:0]      stall_cycles;
  longint           m_stall;
`endif

  svnet_ram_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .READ_LATENCY(RL), .READ_GAP(RG),
                            .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .start_base(start_base), .start_length(start_length),
    .busy(busy), .done(done), .ram_read(ram_read), .ram_read_address(ram_read_address),
    .ram_read_data_valid(ram_read_data_valid), .ram_read_data(ram_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // RAM model, latency 2, contents word[k] = k; idle data bus carries junk.
  logic          p_v;
  logic [AW-1:0] p_a;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v <= 1'b0; p_a <= '0; ram_read_data_valid <= 1'b0; ram_read_data <= '0;
    end else begin
      p_v <= ram_read;
      p_a <= ram_read_address;
      ram_read_data_valid <= p_v;
      ram_read_data <= p_v ? WIDTH'(p_a) : WIDTH'($urandom);
    end
  end

  int nvec = 0, nerr = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: expected address and word queues per burst, busy/done from handshakes.
  int qa[$], qd[$];
  bit ql[$];
  bit m_busy = 0, m_done = 0, prev_stall = 0;
  int cyc = 0, last_rd = -100, issued = 0, accepted = 0, first_valid = -1;
  int rd_times[$], hs_times[$];

  always @(negedge clk) begin
    bit nb, nd;
    int a;
    cyc++;
    if (rst) begin
      qa.delete(); qd.delete(); ql.delete();
      m_busy = 0; m_done = 0; prev_stall = 0; issued = 0; accepted = 0; last_rd = -100;
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
      m_stall = 0;
`endif
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
      chk("stall_cycles", stall_cycles, m_stall);
`endif
      if (prev_stall) chk("valid_hold", out_valid, 1);
      nb = m_busy; nd = 0;
      if (ram_read) begin
        if (qa.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_read: got address %0d expected no read", ram_read_address);
        end else chk("rd_addr", ram_read_address, qa.pop_front());
        chk("rd_gap_ok", (cyc - last_rd) >= RG, 1);
        last_rd = cyc; issued++; rd_times.push_back(cyc);
        chk("credit_ok", (issued - accepted) <= FD, 1);
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (qd.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_valid: got data %0d expected no word", out_data);
        end else begin
          chk("out_data", out_data, qd[0]);
          chk("out_last", out_last, ql[0]);
          if (out_ready) begin
            void'(qd.pop_front());
            if (ql.pop_front()) begin nd = 1; nb = 0; end
            accepted++; hs_times.push_back(cyc);
          end
        end
      end
      if (start && !m_busy) begin
        rd_times.delete(); hs_times.delete(); first_valid = -1;
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
        m_stall = 0;
`endif
        if (start_length != 0) begin
          nb = 1;
          for (int i = 0; i < int'(start_length); i++) begin
            a = (int'(start_base) + i) % DEPTH;
            qa.push_back(a); qd.push_back(a & 8'hFF); ql.push_back(i == int'(start_length) - 1);
          end
        end else nd = 1;
      end
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
      else if (out_valid && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
      prev_stall = out_valid && !out_ready;
      m_busy = nb; m_done = nd;
    end
  end

  int rdy_prob = 100;
  task automatic cycle();
    @(posedge clk); #1;
    out_ready = ($urandom_range(99) < rdy_prob);
  endtask

  task automatic do_start(input int base, input int len);
    start_base = AW'(base); start_length = (AW+1)'(len); start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int k = 0;
    while (!done && k < maxc) begin cycle(); k++; end
    chk({"done_by_", nm}, done, 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, busy, 0);           chk({nm, "_done"}, done, 0);
    chk({nm, "_ram_read"}, ram_read, 0);   chk({nm, "_addr"}, ram_read_address, 0);
    chk({nm, "_valid"}, out_valid, 0);     chk({nm, "_data"}, out_data, 0);
    chk({nm, "_last"}, out_last, 0);
`ifdef SVNET_RAM_STREAM_READER_STATS_EN
    chk({nm, "_stall"}, stall_cycles, 0);
`endif
  endtask

  initial begin
    int k, b, l;
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset");
    rst = 1'b0;
    cycle();

    // Basic burst: reads 5..8 every 2 cycles, first word 3 cycles after first read.
    do_start(5, 4);
    wait_done(100, "basic");
    cycle();
    chk("basic_reads", rd_times.size(), 4);
    chk("basic_words", hs_times.size(), 4);
    if (rd_times.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("basic_read_spacing", rd_times[i] - rd_times[i-1], 2);
      chk("basic_first_valid_lat", first_valid - rd_times[0], RL + 1);
    end
    if (hs_times.size() == 4) chk("basic_throughput", hs_times[3] - hs_times[0], 6);
    chk("basic_busy_after", busy, 0);
    chk("basic_last_addr", ram_read_address, 8);

    // Address wrap at non-power-of-2 DEPTH: 18,19,0,1.
    do_start(18, 4);
    wait_done(100, "wrap");
    cycle();
    chk("wrap_last_addr", ram_read_address, 1);
    chk("wrap_words", hs_times.size(), 4);

    // Backpressure: only FD reads go out while the stream is stalled.
    rdy_prob = 0;
    do_start(0, 16);
    repeat (20) cycle();
    chk("bp_reads_stalled", rd_times.size(), FD);
    chk("bp_valid_stalled", out_valid, 1);
    rdy_prob = 100;
    wait_done(300, "bp");
    cycle();
    chk("bp_reads_total", rd_times.size(), 16);
    chk("bp_words_total", hs_times.size(), 16);

    // Zero-length start, then a start while busy that must be ignored.
    do_start(3, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    cycle();
    do_start(7, 8);
    cycle();
    do_start(0, 5);
    wait_done(200, "ignore");
    cycle();
    chk("ignore_words", hs_times.size(), 8);

    // Reset mid-burst after 3 words accepted.
    do_start(0, 8);
    k = 0;
    while (hs_times.size() < 3 && k < 100) begin cycle(); k++; end
    chk("midrst_reached_3_words", hs_times.size() >= 3, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outs("midrst");
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    do_start(0, 2);
    wait_done(100, "postrst");
    cycle();
    chk("postrst_words", hs_times.size(), 2);

    // Randomized bursts with random backpressure and occasional ignored starts.
    for (int n = 0; n < 30; n++) begin
      rdy_prob = $urandom_range(100, 20);
      b = $urandom_range(DEPTH - 1, 0);
      l = $urandom_range(DEPTH, 0);
      do_start(b, l);
      if (l >= 3 && $urandom_range(1, 0) == 1) begin
        cycle();
        do_start($urandom_range(DEPTH - 1, 0), $urandom_range(DEPTH, 0));
      end
      wait_done(3000, "random");
      cycle();
      chk("random_words", hs_times.size(), l);
      chk("random_queue_empty", qd.size() + qa.size(), 0);
    end
    rdy_prob = 100;
    cycle();

`ifdef SVNET_RAM_STREAM_READER_STATS_EN
    // Seven stalled cycles with a word waiting, then cleared by the next start.
    rdy_prob = 0;
    do_start(0, 4);
    k = 0;
    while (!out_valid && k < 50) begin cycle(); k++; end
    chk("stats_valid_seen", out_valid, 1);
    repeat (6) cycle();
    rdy_prob = 100;
    cycle();
    chk("stats_stall7", stall_cycles, 7);
    wait_done(100, "stats");
    cycle();
    chk("stats_stall7_hold", stall_cycles, 7);
    do_start(2, 1);
    chk("stats_cleared", stall_cycles, 0);
    wait_done(100, "stats2");
    cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
